// File: rtl/dl_capture_pkg.sv
// Shared opcodes, FSM state types and status-byte layout for the delay-line
// capture driver.
package dl_capture_pkg;

    typedef enum logic [3:0] {
        OP_LOAD    = 4'h0,
        OP_UNLOAD  = 4'h1,
        OP_CAPTURE = 4'h2,
        OP_POP     = 4'h3,
        OP_STATUS  = 4'h4
    } opcode_t;

    typedef enum logic {T_IDLE = 1'b0, T_SEND  = 1'b1} tx_state_t;
    typedef enum logic {C_IDLE = 1'b0, C_ARMED = 1'b1} cap_state_t;

    // Status byte: {ovf, udf, tmo, count[4:0]}
    localparam int ST_OVF   = 7;
    localparam int ST_UDF   = 6;
    localparam int ST_TMO   = 5;
    localparam int ST_CNT_W = 5;

endpackage

// File: rtl/dl_capture_driver_if.sv
// Host byte path (RX/TX) and delay-line sample bus of the capture driver.
interface dl_capture_driver_if #(
    parameter int DL_W   = 32,
    parameter int NUM_CH = 2
);
    logic                   i_valid;
    logic [7:0]             i_data;
    logic                   o_valid;
    logic                   i_accept;
    logic [7:0]             o_data;
    logic [NUM_CH-1:0]      i_dl_valid;
    logic [NUM_CH*DL_W-1:0] i_dl;
    logic                   o_busy;
    logic                   o_armed;

    modport slave (
        input  i_valid, i_data, i_accept, i_dl_valid, i_dl,
        output o_valid, o_data, o_busy, o_armed
    );

    modport master (
        output i_valid, i_data, i_accept, i_dl_valid, i_dl,
        input  o_valid, o_data, o_busy, o_armed
    );
endinterface

// File: rtl/dl_capture_fifo.sv
// Power-of-two capture FIFO; push on full is dropped unless a pop frees a slot
// in the same cycle.
module dl_capture_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_ok;

    assign o_full  = (count_q == (AW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];
    assign wr_ok   = i_push && (!o_full || i_pop);
    assign o_drop  = i_push && o_full && !i_pop;

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= i_push_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (i_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(wr_ok) - (AW+1)'(i_pop);
        end
    end
endmodule

// File: rtl/dl_capture_driver.sv
// Host-command decoder: arms capture windows on delay-line channels, buffers
// samples, and streams DL_W-bit words MSB byte first to the TX path.
module dl_capture_driver
    import dl_capture_pkg::*;
#(
    parameter int DL_W    = 32,
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 4,
    parameter int CAP_WIN = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    dl_capture_driver_if.slave bus
);
    localparam int NB  = DL_W / 8;
    localparam int BLW = $clog2(NB + 1);
    localparam int TW  = (CAP_WIN > 1) ? $clog2(CAP_WIN) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;

    tx_state_t        tx_state_q;
    cap_state_t       cap_state_q;
    logic [DL_W-1:0]  tx_q;
    logic [BLW-1:0]   bytes_left_q;
    logic [3:0]       ch_q;
    logic [TW-1:0]    timer_q;
    logic             ovf_q, udf_q, tmo_q;
    logic             ovf_d, udf_d, tmo_d;

    logic [3:0]       op, arg, sel_ch;
    logic             idle_cmd, cap_cmd, sel_vld, push, pop, status, timeout;
    logic [DL_W-1:0]  sel_dat, head;
    logic             fifo_full, empty, drop;
    logic [CW-1:0]    count;
    logic [7:0]       st_byte;

    assign op       = bus.i_data[3:0];
    assign arg      = bus.i_data[7:4];
    assign idle_cmd = bus.i_valid && (tx_state_q == T_IDLE);
    assign cap_cmd  = bus.i_valid && (op == OP_CAPTURE) && ({1'b0, arg} < 5'(NUM_CH));
    assign sel_ch   = cap_cmd ? arg : ch_q;

    // A fresh CAPTURE samples its own channel in the command cycle.
    always_comb begin
        sel_vld = 1'b0;
        sel_dat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (4'(c) == sel_ch) begin
                sel_vld = bus.i_dl_valid[c];
                sel_dat = bus.i_dl[c*DL_W +: DL_W];
            end
        end
    end

    assign push    = (cap_cmd || (cap_state_q == C_ARMED)) && sel_vld;
    assign timeout = !cap_cmd && (cap_state_q == C_ARMED) && !sel_vld && (timer_q == '0);
    assign pop     = idle_cmd && (op == OP_POP) && !empty;
    assign status  = idle_cmd && (op == OP_STATUS);

    always_comb begin
        st_byte                 = '0;
        st_byte[ST_OVF]         = ovf_q;
        st_byte[ST_UDF]         = udf_q;
        st_byte[ST_TMO]         = tmo_q;
        st_byte[ST_CNT_W-1:0]   = ST_CNT_W'(count);
        // STATUS reports the old flags; a same-cycle event leaves its flag set.
        ovf_d = (ovf_q && !status) || drop;
        udf_d = (udf_q && !status) || (idle_cmd && (op == OP_POP) && empty);
        tmo_d = (tmo_q && !status) || timeout;
    end

    dl_capture_fifo #(.WIDTH(DL_W), .DEPTH(DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_push_data (sel_dat),
        .i_pop       (pop),
        .o_head      (head),
        .o_full      (fifo_full),
        .o_empty     (empty),
        .o_count     (count),
        .o_drop      (drop)
    );

    assert property (@(posedge i_clk) disable iff (!i_rst_n) drop |-> fifo_full);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tx_state_q   <= T_IDLE;
            tx_q         <= '0;
            bytes_left_q <= '0;
        end else if (tx_state_q == T_SEND) begin
            if (bus.i_accept) begin
                tx_q         <= tx_q << 8;
                bytes_left_q <= bytes_left_q - 1'b1;
                if (bytes_left_q == BLW'(1)) tx_state_q <= T_IDLE;
            end
        end else if (bus.i_valid) begin
            case (op)
                OP_LOAD:   tx_q <= {tx_q[DL_W-5:0], arg};
                OP_UNLOAD: begin
                    tx_state_q   <= T_SEND;
                    bytes_left_q <= BLW'(NB);
                end
                OP_POP:    if (!empty) tx_q <= head;
                OP_STATUS: tx_q <= DL_W'(st_byte) << (DL_W - 8);
                default:   ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cap_state_q <= C_IDLE;
            ch_q        <= '0;
            timer_q     <= '0;
        end else if (cap_cmd) begin
            ch_q        <= arg;
            timer_q     <= TW'(CAP_WIN - 1);
            cap_state_q <= sel_vld ? C_IDLE : C_ARMED;
        end else if (cap_state_q == C_ARMED) begin
            if (sel_vld || timer_q == '0) cap_state_q <= C_IDLE;
            else                          timer_q     <= timer_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            tmo_q <= tmo_d;
        end
    end

    assign bus.o_valid = (tx_state_q == T_SEND);
    assign bus.o_busy  = (tx_state_q == T_SEND);
    assign bus.o_armed = (cap_state_q == C_ARMED);
    assign bus.o_data  = tx_q[DL_W-1:DL_W-8];
endmodule

// File: tb/tb_dl_capture_driver.sv
// Directed bench for dl_capture_driver: queue-based reference model checked
// every cycle, plus literal byte-stream expectations per scenario.
module tb_dl_capture_driver;
    localparam int DL_W = 32, NUM_CH = 2, DEPTH = 4, CAP_WIN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0, failures = 0;
    logic [7:0] got[$];

    dl_capture_driver_if #(.DL_W(DL_W), .NUM_CH(NUM_CH)) bus ();

    dl_capture_driver #(.DL_W(DL_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .CAP_WIN(CAP_WIN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: word register, byte countdown, window countdown, sample queue.
    logic        m_send = 0, m_armed = 0, m_ovf = 0, m_udf = 0, m_tmo = 0;
    int          m_left = 0, m_ch = 0, m_win = 0;
    logic [31:0] m_tx = '0;
    logic [31:0] m_q[$];

    always @(posedge clk) begin : model
        logic [3:0]  op, arg;
        logic        st, popd, psh, tmo_ev;
        logic [31:0] pv;
        int          sz;
        if (rst_n && bus.o_valid && bus.i_accept) got.push_back(bus.o_data);
        op = bus.i_data[3:0]; arg = bus.i_data[7:4];
        st = 0; popd = 0; psh = 0; tmo_ev = 0; pv = '0;
        if (!rst_n) begin
            m_send = 0; m_armed = 0; m_ovf = 0; m_udf = 0; m_tmo = 0;
            m_left = 0; m_tx = '0; m_q.delete();
        end else begin
            if (bus.i_valid && op == 4'h2 && int'(arg) < NUM_CH) begin
                if (bus.i_dl_valid[int'(arg)]) begin
                    psh = 1; pv = bus.i_dl[int'(arg)*DL_W +: DL_W]; m_armed = 0;
                end else begin
                    m_armed = 1; m_ch = int'(arg); m_win = CAP_WIN;
                end
            end else if (m_armed) begin
                if (bus.i_dl_valid[m_ch]) begin
                    psh = 1; pv = bus.i_dl[m_ch*DL_W +: DL_W]; m_armed = 0;
                end else begin
                    m_win--;
                    if (m_win == 0) begin m_armed = 0; tmo_ev = 1; end
                end
            end
            if (m_send) begin
                if (bus.i_accept) begin
                    m_tx = m_tx << 8; m_left--;
                    if (m_left == 0) m_send = 0;
                end
            end else if (bus.i_valid) begin
                case (op)
                    4'h0: m_tx = {m_tx[27:0], arg};
                    4'h1: begin m_send = 1; m_left = DL_W / 8; end
                    4'h3: if (m_q.size() > 0) begin m_tx = m_q[0]; popd = 1; end else m_udf = 1;
                    4'h4: begin m_tx = {m_ovf, m_udf, m_tmo, 5'(m_q.size()), 24'h0}; st = 1; end
                    default: ;
                endcase
            end
            sz = m_q.size();
            if (st) begin m_ovf = 0; m_udf = 0; m_tmo = 0; end
            if (popd) void'(m_q.pop_front());
            if (psh) begin
                if (sz == DEPTH && !popd) m_ovf = 1;
                else m_q.push_back(pv);
            end
            if (tmo_ev) m_tmo = 1;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cyc_o_valid", {31'b0, bus.o_valid}, {31'b0, m_send});
        chk("cyc_o_busy",  {31'b0, bus.o_busy},  {31'b0, m_send});
        chk("cyc_o_armed", {31'b0, bus.o_armed}, {31'b0, m_armed});
        chk("cyc_o_data",  {24'b0, bus.o_data},  {24'b0, m_tx[31:24]});
    end

    task automatic send(input logic [3:0] op, input logic [3:0] arg);
        bus.i_valid = 1'b1;
        bus.i_data  = {arg, op};
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int i = 7; i >= 0; i--) send(4'h0, w[i*4 +: 4]);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && bus.o_busy; k++) @(negedge clk);
        chk("idle_bound", {31'b0, bus.o_busy}, 32'd0);
    endtask

    task automatic unload_expect(input string nm, input logic [31:0] w);
        send(4'h1, 4'h0);
        chk({nm, "_valid_rise"}, {31'b0, bus.o_valid}, 32'd1);
        wait_idle();
        chk({nm, "_nbytes"}, got.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk({nm, "_byte"}, (i < got.size()) ? {24'b0, got[i]} : 32'hFFFF_FFFF, {24'b0, w[(3-i)*8 +: 8]});
        got.delete();
    endtask

    task automatic cap_now(input int ch, input logic [31:0] d);
        bus.i_dl[ch*DL_W +: DL_W] = d;
        bus.i_dl_valid = NUM_CH'(1) << ch;
        send(4'h2, 4'(ch));
        bus.i_dl_valid = '0;
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1001;
        bus.i_valid = 0; bus.i_data = '0; bus.i_accept = 1;
        bus.i_dl_valid = '0; bus.i_dl = '0;
        repeat (3) @(negedge clk);
        chk("rst_o_valid", {31'b0, bus.o_valid}, 32'd0);
        chk("rst_o_data",  {24'b0, bus.o_data},  32'd0);
        chk("rst_o_busy",  {31'b0, bus.o_busy},  32'd0);
        chk("rst_o_armed", {31'b0, bus.o_armed}, 32'd0);
        rst_n = 1;
        @(negedge clk);

        // Straight unload, accept held high
        load_word(32'hDEAD_BEEF);
        chk("t1_pre_valid", {31'b0, bus.o_valid}, 32'd0);
        unload_expect("t1", 32'hDEAD_BEEF);

        // Stalled unload with LOAD dropped mid-word
        load_word(32'hDEAD_BEEF);
        send(4'h1, 4'h0);
        for (int k = 0; k < 40 && bus.o_busy; k++) begin
            bus.i_accept = pat[k % 4];
            bus.i_valid  = (k == 1);
            bus.i_data   = 8'h50;
            @(negedge clk);
        end
        bus.i_valid = 0; bus.i_data = '0; bus.i_accept = 1;
        chk("t2_nbytes", got.size(), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("t2_byte", {24'b0, got[i]}, {24'b0, 8'hDE, 8'hAD, 8'hBE, 8'hEF} >> ((3-i)*8) & 32'hFF);
        got.delete();
        chk("t2_load_dropped", {24'b0, bus.o_data}, 32'd0);

        // Capture on ch1, ch0 valids ignored
        bus.i_dl = {32'h1234_5678, 32'hAAAA_5555};
        bus.i_dl_valid = 2'b01;
        send(4'h2, 4'h1);
        chk("t3_armed", {31'b0, bus.o_armed}, 32'd1);
        bus.i_dl_valid = 2'b11;
        @(negedge clk);
        bus.i_dl_valid = 2'b00;
        chk("t3_disarmed", {31'b0, bus.o_armed}, 32'd0);
        send(4'h3, 4'h0);
        unload_expect("t3", 32'h1234_5678);

        // Window timeout
        send(4'h2, 4'h0);
        chk("t4_armed", {31'b0, bus.o_armed}, 32'd1);
        for (int k = 0; k < 10 && bus.o_armed; k++) @(negedge clk);
        chk("t4_closed", {31'b0, bus.o_armed}, 32'd0);
        send(4'h4, 4'h0);
        unload_expect("t4_status", 32'h2000_0000);
        send(4'h4, 4'h0);
        unload_expect("t4_status2", 32'h0000_0000);

        // Overflow then underflow
        for (int k = 0; k < 5; k++) cap_now(0, 32'h100 + k);
        send(4'h4, 4'h0);
        unload_expect("t5_ovf", 32'h8400_0000);
        for (int k = 0; k < 5; k++) send(4'h3, 4'h0);
        unload_expect("t5_lastpop", 32'h0000_0103);
        send(4'h4, 4'h0);
        unload_expect("t5_udf", 32'h4000_0000);

        // Push and pop in one cycle while full
        for (int k = 0; k < 4; k++) cap_now(0, 32'h200 + k);
        bus.i_dl_valid = '0;
        send(4'h2, 4'h1);
        bus.i_dl[DL_W +: DL_W] = 32'hCAFE_0001;
        bus.i_dl_valid = 2'b10;
        send(4'h3, 4'h0);
        bus.i_dl_valid = '0;
        send(4'h4, 4'h0);
        unload_expect("t6_full_pushpop", 32'h0400_0000);
        for (int k = 0; k < 4; k++) send(4'h3, 4'h0);
        unload_expect("t6_tail", 32'hCAFE_0001);

        // Reset mid-word and mid-window
        load_word(32'h5A5A_5A5A);
        bus.i_accept = 0;
        send(4'h1, 4'h0);
        send(4'h2, 4'h0);
        chk("t7_busy_pre",  {31'b0, bus.o_busy},  32'd1);
        chk("t7_armed_pre", {31'b0, bus.o_armed}, 32'd1);
        rst_n = 0;
        @(negedge clk);
        chk("t7_o_valid", {31'b0, bus.o_valid}, 32'd0);
        chk("t7_o_busy",  {31'b0, bus.o_busy},  32'd0);
        chk("t7_o_armed", {31'b0, bus.o_armed}, 32'd0);
        chk("t7_o_data",  {24'b0, bus.o_data},  32'd0);
        chk("t7_no_bytes", got.size(), 32'd0);
        rst_n = 1;
        bus.i_accept = 1;
        @(negedge clk);
        send(4'h4, 4'h0);
        unload_expect("t7_status", 32'h0000_0000);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
